dvp_capture: RTL and testbench

- Front-end capture stage of the DVP video path. Sits directly upstream of the crop stage.
- Converts the camera's 8-bit DVP byte stream (RGB565, two bytes per pixel) into the 24-bit RGB888 vs/de/data stream the crop stage consumes.
- Discards the first frames after reset while the sensor settles.
- Reports the measured line width and frame height for software sanity checks.

---
 rtl/dvp_capture.sv | 226 ++++++++++++++++++++++
 tb/tb_dvp_capture.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dvp_capture.sv
// dvp_capture: turns the camera's 8-bit RGB565 DVP byte stream into a 24-bit
// RGB888 vs/de/data stream. It discards the settle frames after reset, gates
// output per frame with EN, and measures the width of the last line and the
// height of the last frame.
module dvp_capture #(
    parameter int unsigned FRAME_SKIP = 10,
    parameter bit          VS_POL     = 1'b1,
    parameter int unsigned CNT_WIDTH  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 EN,
    input  logic                 cam_vsync,
    input  logic                 cam_href,
    input  logic [7:0]           cam_data,
    output logic                 post_vs,
    output logic                 post_de,
    output logic [23:0]          post_data,
    output logic                 frame_ok,
    output logic [CNT_WIDTH-1:0] line_width,
    output logic [CNT_WIDTH-1:0] frame_lines
);

    localparam logic [7:0]           SKIP_C   = 8'(FRAME_SKIP);
    localparam logic [7:0]           FCNT_MAX = 8'hFF;
    localparam logic [7:0]           FCNT_ONE = 8'h01;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    // XOR mask that normalises the camera vsync to active-high.
    localparam logic                 VS_INV   = ~VS_POL;

    // Input stage (d1) plus one extra delay used for edge detection.
    logic                 vs_d1_r;
    logic                 vs_d2_r;
    logic                 href_d1_r;
    logic                 href_d2_r;
    logic [7:0]           data_d1_r;

    // Byte assembly.
    logic                 phase_r;
    logic [7:0]           hi_r;

    // Frame skip and per-frame enable.
    logic [7:0]           frame_cnt_r;
    logic                 frame_ok_r;
    logic                 en_frame_r;

    // Measurement.
    logic [CNT_WIDTH-1:0] pix_cnt_r;
    logic [CNT_WIDTH-1:0] line_cnt_r;
    logic [CNT_WIDTH-1:0] line_width_r;
    logic [CNT_WIDTH-1:0] frame_lines_r;

    // Output registers.
    logic                 post_vs_r;
    logic                 post_de_r;
    logic [23:0]          post_data_r;

    // Decoded events and look-ahead gating terms.
    logic                 frame_start_s;
    logic                 href_fall_s;
    logic                 pixel_s;
    logic                 frame_ok_nxt_s;
    logic                 en_frame_nxt_s;
    logic                 live_s;
    logic [23:0]          rgb_s;

    // Saturating increment for the measurement counters.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        logic [CNT_WIDTH-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

    // RGB565 to RGB888: each channel's MSBs are replicated into its LSBs, so
    // full scale maps to 8'hFF and zero maps to 8'h00.
    function automatic logic [23:0] rgb565_to_888(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:3], hi[7:5], hi[2:0], lo[7:5], hi[2:1], lo[4:0], lo[4:2]};
    endfunction

    // Decode frame/line/pixel events and the gating state that applies this cycle.
    always_comb begin
        frame_start_s  = 1'b0;
        href_fall_s    = 1'b0;
        pixel_s        = 1'b0;
        frame_ok_nxt_s = frame_ok_r;
        en_frame_nxt_s = en_frame_r;
        live_s         = 1'b0;
        rgb_s          = 24'h000000;

        frame_start_s = vs_d1_r & ~vs_d2_r;
        href_fall_s   = href_d2_r & ~href_d1_r;
        pixel_s       = href_d1_r & phase_r;
        rgb_s         = rgb565_to_888(hi_r, data_d1_r);

        // The gating decision for a new frame is made on its first cycle, so
        // its post_vs and every one of its pixels share the same verdict.
        if (frame_start_s) begin
            en_frame_nxt_s = EN;
            frame_ok_nxt_s = frame_ok_r | (frame_cnt_r == SKIP_C);
        end else begin
            en_frame_nxt_s = en_frame_r;
            frame_ok_nxt_s = frame_ok_r;
        end
        live_s = frame_ok_nxt_s & en_frame_nxt_s;
    end

    // Register the camera inputs once and keep a second vsync/href stage for edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d1_r   <= 1'b0;
            vs_d2_r   <= 1'b0;
            href_d1_r <= 1'b0;
            href_d2_r <= 1'b0;
            data_d1_r <= 8'h00;
        end else begin
            vs_d1_r   <= cam_vsync ^ VS_INV;
            vs_d2_r   <= vs_d1_r;
            href_d1_r <= cam_href;
            href_d2_r <= href_d1_r;
            data_d1_r <= cam_data;
        end
    end

    // Byte phase tracking: phase 0 captures the high byte, phase 1 completes a pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_r <= 1'b0;
            hi_r    <= 8'h00;
        end else if (href_d1_r) begin
            phase_r <= ~phase_r;
            if (!phase_r) begin
                hi_r <= data_d1_r;
            end else begin
                hi_r <= hi_r;
            end
        end else begin
            // Outside a line the phase is forced back, which also drops an
            // odd trailing byte.
            phase_r <= 1'b0;
            hi_r    <= hi_r;
        end
    end

    // Frame counter, sticky frame_ok and the per-frame enable latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= 8'h00;
            frame_ok_r  <= 1'b0;
            en_frame_r  <= 1'b0;
        end else begin
            frame_ok_r <= frame_ok_nxt_s;
            en_frame_r <= en_frame_nxt_s;
            if (frame_start_s && (frame_cnt_r != FCNT_MAX)) begin
                frame_cnt_r <= frame_cnt_r + FCNT_ONE;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    // Pixels-per-line measurement, latched when href falls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_cnt_r    <= CNT_ZERO;
            line_width_r <= CNT_ZERO;
        end else if (pixel_s) begin
            pix_cnt_r <= sat_inc(pix_cnt_r);
        end else if (href_fall_s) begin
            line_width_r <= pix_cnt_r;
            pix_cnt_r    <= CNT_ZERO;
        end else begin
            pix_cnt_r <= pix_cnt_r;
        end
    end

    // Lines-per-frame measurement. A line that ends on the frame-start cycle
    // still belongs to the frame that is ending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_cnt_r    <= CNT_ZERO;
            frame_lines_r <= CNT_ZERO;
        end else if (frame_start_s) begin
            if (href_fall_s) begin
                frame_lines_r <= sat_inc(line_cnt_r);
            end else begin
                frame_lines_r <= line_cnt_r;
            end
            line_cnt_r <= CNT_ZERO;
        end else if (href_fall_s) begin
            line_cnt_r <= sat_inc(line_cnt_r);
        end else begin
            line_cnt_r <= line_cnt_r;
        end
    end

    // Registered, gated video outputs. Data is held at zero between pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            post_vs_r   <= 1'b0;
            post_de_r   <= 1'b0;
            post_data_r <= 24'h000000;
        end else begin
            post_vs_r <= vs_d1_r & live_s;
            post_de_r <= pixel_s & live_s;
            if (pixel_s && live_s) begin
                post_data_r <= rgb_s;
            end else begin
                post_data_r <= 24'h000000;
            end
        end
    end

    assign post_vs     = post_vs_r;
    assign post_de     = post_de_r;
    assign post_data   = post_data_r;
    assign frame_ok    = frame_ok_r;
    assign line_width  = line_width_r;
    assign frame_lines = frame_lines_r;

endmodule

// File: tb/tb_dvp_capture.sv
// Bench for dvp_capture. Two instances share one stimulus stream:
//   A: FRAME_SKIP=2, active-high vsync, 12-bit counters
//   B: FRAME_SKIP=0, active-low vsync (driven inverted), 4-bit counters
// A reference model predicts the pixels of each frame, the frame_ok state and
// the measurements. The predicted pixels are compared with what a monitor
// collects.
module tb_dvp_capture;

    localparam int SKIP_A = 2;
    localparam int SKIP_B = 0;
    localparam int MAX_A  = 4095;
    localparam int MAX_B  = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        vs;
    logic        href;
    logic [7:0]  data;
    logic        cam_vsync_b;

    logic        post_vs_a, post_de_a, frame_ok_a;
    logic [23:0] post_data_a;
    logic [11:0] line_width_a, frame_lines_a;
    logic        post_vs_b, post_de_b, frame_ok_b;
    logic [23:0] post_data_b;
    logic [3:0]  line_width_b, frame_lines_b;

    int checks = 0;
    int errors = 0;

    // Monitor state.
    logic [23:0] got_a[$];
    logic [23:0] got_b[$];
    int          vs_cnt_a = 0;
    int          vs_cnt_b = 0;
    int          idle_bad = 0;

    // Reference model state.
    logic [23:0] exp_a[$];
    logic [23:0] exp_b[$];
    int          frames_m = 0;
    int          lines_m  = 0;
    int          width_m  = 0;
    bit          en_lat   = 1'b0;
    bit          live_a   = 1'b0;
    bit          live_b   = 1'b0;

    assign cam_vsync_b = ~vs;

    always #5 clk = ~clk;

    dvp_capture #(.FRAME_SKIP(SKIP_A), .VS_POL(1'b1), .CNT_WIDTH(12)) u_dut_a (
        .clk(clk), .rst(rst), .EN(en), .cam_vsync(vs), .cam_href(href), .cam_data(data),
        .post_vs(post_vs_a), .post_de(post_de_a), .post_data(post_data_a),
        .frame_ok(frame_ok_a), .line_width(line_width_a), .frame_lines(frame_lines_a)
    );

    dvp_capture #(.FRAME_SKIP(SKIP_B), .VS_POL(1'b0), .CNT_WIDTH(4)) u_dut_b (
        .clk(clk), .rst(rst), .EN(en), .cam_vsync(cam_vsync_b), .cam_href(href), .cam_data(data),
        .post_vs(post_vs_b), .post_de(post_de_b), .post_data(post_data_b),
        .frame_ok(frame_ok_b), .line_width(line_width_b), .frame_lines(frame_lines_b)
    );

    // Monitor: samples the outputs 2 time units after each rising edge.
    always @(posedge clk) begin
        #2;
        if (post_de_a) got_a.push_back(post_data_a);
        else if (post_data_a !== 24'h0) idle_bad++;
        if (post_de_b) got_b.push_back(post_data_b);
        else if (post_data_b !== 24'h0) idle_bad++;
        if (post_vs_a) vs_cnt_a++;
        if (post_vs_b) vs_cnt_b++;
    end

    // Watchdog.
    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // Standard 5:6:5 to 8:8:8 widening: scale each channel by replicating its top bits.
    function automatic logic [23:0] rgb888(input logic [7:0] hi, input logic [7:0] lo);
        int r5, g6, b5, r, g, b;
        r5 = int'(hi) / 8;
        g6 = (int'(hi) % 8) * 8 + int'(lo) / 32;
        b5 = int'(lo) % 32;
        r  = r5 * 8 + r5 / 4;
        g  = g6 * 4 + g6 / 16;
        b  = b5 * 8 + b5 / 4;
        return 24'(r * 65536 + g * 256 + b);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Drives one line of random bytes and records the expected pixels.
    // With merge_vs set, href stays up until the caller starts vsync.
    task automatic send_line(input int nbytes, input bit merge_vs);
        logic [7:0] hi_byte;
        hi_byte = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            href = 1'b1;
            data = 8'($urandom_range(0, 255));
            if (i % 2 == 0) begin
                hi_byte = data;
            end else begin
                if (live_a) exp_a.push_back(rgb888(hi_byte, data));
                if (live_b) exp_b.push_back(rgb888(hi_byte, data));
            end
            @(negedge clk);
        end
        lines_m++;
        width_m = nbytes / 2;
        if (!merge_vs) begin
            href = 1'b0;
            data = 8'h00;
            repeat (4) @(negedge clk);
        end
    endtask

    // Vsync pulse: closes the previous frame (pixel comparison), then checks
    // the state of the new frame.
    task automatic vsync_pulse();
        int first;
        int exp_lines;
        href = 1'b0;
        data = 8'h00;
        vs   = 1'b1;
        vs_cnt_a = 0;
        vs_cnt_b = 0;
        repeat (2) @(negedge clk);

        checks++;
        if (got_a.size() != exp_a.size()) begin
            errors++;
            $display("FAIL pix_count_a frame %0d: got %0d expected %0d", frames_m, got_a.size(), exp_a.size());
        end else begin
            checks++;
            first = -1;
            foreach (got_a[i]) if (first < 0 && got_a[i] !== exp_a[i]) first = i;
            if (first >= 0) begin
                errors++;
                $display("FAIL pix_data_a frame %0d idx %0d: got %h expected %h", frames_m, first, got_a[first], exp_a[first]);
            end
        end
        checks++;
        if (got_b.size() != exp_b.size()) begin
            errors++;
            $display("FAIL pix_count_b frame %0d: got %0d expected %0d", frames_m, got_b.size(), exp_b.size());
        end else begin
            checks++;
            first = -1;
            foreach (got_b[i]) if (first < 0 && got_b[i] !== exp_b[i]) first = i;
            if (first >= 0) begin
                errors++;
                $display("FAIL pix_data_b frame %0d idx %0d: got %h expected %h", frames_m, first, got_b[first], exp_b[first]);
            end
        end
        got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();

        // Model of the frame start.
        exp_lines = lines_m;
        lines_m   = 0;
        frames_m++;
        en_lat = en;
        live_a = (frames_m >= SKIP_A + 1) && en_lat;
        live_b = (frames_m >= SKIP_B + 1) && en_lat;

        @(negedge clk);
        vs = 1'b0;
        repeat (4) @(negedge clk);

        checks++;
        if (frame_ok_a !== (frames_m >= SKIP_A + 1)) begin
            errors++;
            $display("FAIL frame_ok_a frame %0d: got %b expected %b", frames_m, frame_ok_a, frames_m >= SKIP_A + 1);
        end
        checks++;
        if (frame_ok_b !== (frames_m >= SKIP_B + 1)) begin
            errors++;
            $display("FAIL frame_ok_b frame %0d: got %b expected %b", frames_m, frame_ok_b, frames_m >= SKIP_B + 1);
        end
        checks++;
        if (frame_lines_a !== 12'(sat(exp_lines, MAX_A)) || line_width_a !== 12'(sat(width_m, MAX_A))) begin
            errors++;
            $display("FAIL measure_a frame %0d: got lines %0d width %0d expected lines %0d width %0d",
                     frames_m, frame_lines_a, line_width_a, sat(exp_lines, MAX_A), sat(width_m, MAX_A));
        end
        checks++;
        if (frame_lines_b !== 4'(sat(exp_lines, MAX_B)) || line_width_b !== 4'(sat(width_m, MAX_B))) begin
            errors++;
            $display("FAIL measure_b frame %0d: got lines %0d width %0d expected lines %0d width %0d",
                     frames_m, frame_lines_b, line_width_b, sat(exp_lines, MAX_B), sat(width_m, MAX_B));
        end
        checks++;
        if (vs_cnt_a != (live_a ? 3 : 0) || vs_cnt_b != (live_b ? 3 : 0)) begin
            errors++;
            $display("FAIL post_vs frame %0d: got a=%0d b=%0d cycles expected a=%0d b=%0d",
                     frames_m, vs_cnt_a, vs_cnt_b, live_a ? 3 : 0, live_b ? 3 : 0);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({post_vs_a, post_de_a, post_data_a, frame_ok_a, line_width_a, frame_lines_a} !== 51'd0) begin
            errors++;
            $display("FAIL reset_a: got %h expected 0", {post_vs_a, post_de_a, post_data_a, frame_ok_a, line_width_a, frame_lines_a});
        end
        checks++;
        if ({post_vs_b, post_de_b, post_data_b, frame_ok_b, line_width_b, frame_lines_b} !== 35'd0) begin
            errors++;
            $display("FAIL reset_b: got %h expected 0", {post_vs_b, post_de_b, post_data_b, frame_ok_b, line_width_b, frame_lines_b});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame_skip();
        en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            vsync_pulse();
            for (int l = 0; l < 4; l++) send_line(6, 1'b0);
        end
    endtask

    task automatic test_colour();
        logic [7:0]  hv [4];
        logic [7:0]  lv [4];
        logic [23:0] ev [4];
        hv = '{8'hF8, 8'h07, 8'h00, 8'hFF};
        lv = '{8'h00, 8'hE0, 8'h1F, 8'hFF};
        ev = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};
        vsync_pulse();
        for (int k = 0; k < 4; k++) begin
            href = 1'b1;
            data = hv[k];
            if (live_a) exp_a.push_back(ev[k]);
            if (live_b) exp_b.push_back(ev[k]);
            @(negedge clk);
            data = lv[k];
            @(negedge clk);
            href = 1'b0;
            data = 8'h00;
            checks++;
            if (post_de_a !== 1'b0) begin
                errors++;
                $display("FAIL colour_early %0d: got de %b expected 0", k, post_de_a);
            end
            @(negedge clk);
            checks++;
            if (post_de_a !== live_a || post_data_a !== (live_a ? ev[k] : 24'h0)) begin
                errors++;
                $display("FAIL colour_a %0d: got de %b data %h expected de %b data %h", k, post_de_a, post_data_a, live_a, ev[k]);
            end
            checks++;
            if (post_de_b !== live_b || post_data_b !== (live_b ? ev[k] : 24'h0)) begin
                errors++;
                $display("FAIL colour_b %0d: got de %b data %h expected de %b data %h", k, post_de_b, post_data_b, live_b, ev[k]);
            end
            @(negedge clk);
            checks++;
            if (post_de_a !== 1'b0 || line_width_a !== 12'd1) begin
                errors++;
                $display("FAIL colour_pulse %0d: got de %b width %0d expected de 0 width 1", k, post_de_a, line_width_a);
            end
            lines_m++;
            width_m = 1;
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic test_odd_line();
        int nb [3];
        nb = '{7, 6, 9};
        vsync_pulse();
        for (int k = 0; k < 3; k++) begin
            send_line(nb[k], 1'b0);
            checks++;
            if (line_width_a !== 12'(nb[k] / 2) || line_width_b !== 4'(nb[k] / 2)) begin
                errors++;
                $display("FAIL odd_line %0d: got a=%0d b=%0d expected %0d", nb[k], line_width_a, line_width_b, nb[k] / 2);
            end
        end
    endtask

    task automatic test_simultaneous();
        vsync_pulse();
        send_line(10, 1'b0);
        send_line(10, 1'b0);
        send_line(14, 1'b1);
        vsync_pulse();
        checks++;
        if (frame_lines_a !== 12'd3 || line_width_a !== 12'd7) begin
            errors++;
            $display("FAIL simultaneous: got lines %0d width %0d expected lines 3 width 7", frame_lines_a, line_width_a);
        end
    endtask

    task automatic test_en_gating();
        en = 1'b1;
        vsync_pulse();
        send_line(8, 1'b0); send_line(8, 1'b0);
        en = 1'b0;
        send_line(8, 1'b0); send_line(8, 1'b0);
        vsync_pulse();
        send_line(8, 1'b0); send_line(8, 1'b0);
        en = 1'b1;
        send_line(8, 1'b0); send_line(8, 1'b0);
        vsync_pulse();
        send_line(8, 1'b0); send_line(8, 1'b0);
    endtask

    task automatic test_measure();
        vsync_pulse();
        for (int l = 0; l < 40; l++) send_line(200, 1'b0);
        vsync_pulse();
        checks++;
        if (frame_lines_a !== 12'd40 || line_width_a !== 12'd100) begin
            errors++;
            $display("FAIL measure_big: got lines %0d width %0d expected lines 40 width 100", frame_lines_a, line_width_a);
        end
        checks++;
        if (frame_lines_b !== 4'd15 || line_width_b !== 4'd15) begin
            errors++;
            $display("FAIL measure_sat: got lines %0d width %0d expected lines 15 width 15", frame_lines_b, line_width_b);
        end
    endtask

    task automatic test_reset_mid();
        vsync_pulse();
        send_line(6, 1'b0);
        for (int i = 0; i < 3; i++) begin
            href = 1'b1;
            data = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        checks++;
        if (frame_ok_a !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_ok: got %b expected 1", frame_ok_a);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({post_vs_a, post_de_a, post_data_a, frame_ok_a, line_width_a, frame_lines_a} !== 51'd0) begin
            errors++;
            $display("FAIL mid_reset_a: got %h expected 0", {post_vs_a, post_de_a, post_data_a, frame_ok_a, line_width_a, frame_lines_a});
        end
        checks++;
        if ({post_vs_b, post_de_b, post_data_b, frame_ok_b, line_width_b, frame_lines_b} !== 35'd0) begin
            errors++;
            $display("FAIL mid_reset_b: got %h expected 0", {post_vs_b, post_de_b, post_data_b, frame_ok_b, line_width_b, frame_lines_b});
        end
        @(negedge clk);
        href = 1'b0;
        data = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
        frames_m = 0; lines_m = 0; width_m = 0;
        en_lat = 1'b0; live_a = 1'b0; live_b = 1'b0;
        for (int f = 0; f < 3; f++) begin
            vsync_pulse();
            send_line(8, 1'b0);
            send_line(8, 1'b0);
        end
        vsync_pulse();
    endtask

    task automatic test_idle();
        checks++;
        if (idle_bad != 0) begin
            errors++;
            $display("FAIL idle_data: got %0d nonzero idle samples expected 0", idle_bad);
        end
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b1;
        vs   = 1'b0;
        href = 1'b0;
        data = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        test_frame_skip();
        test_colour();
        test_odd_line();
        test_simultaneous();
        test_en_gating();
        test_measure();
        test_reset_mid();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
